// File: rtl/ifetch_q_pkg.sv
// rtl/ifetch_q_pkg.sv - shared widths and encodings for the fetch stage
package ifetch_q_pkg;

   // Default PC/memory word-address and instruction widths
   localparam int ADDR_W = 32;
   localparam int INST_W = 32;

   // NOP encoding used to fill instruction memories; fetch never injects it
   localparam logic [31:0] NOP = 32'h0000_0013;

   // Width of an occupancy counter that must represent 0..depth inclusive
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush for fetched {pc, inst} pairs
module fetch_fifo
   import ifetch_q_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           dout,
   output logic                       empty,
   output logic                       full,
   output logic [cnt_w(DEPTH)-1:0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             pop_ok;
   logic             push_ok;

   // A pop on an empty queue is ignored; a push when full is only taken
   // together with a pop, which frees the slot being written.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign dout  = mem[rd_ptr];

   // Entry storage; flush leaves stale data behind since count gates validity
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push_ok && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy update; flush overrides any push or pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ifetch_q.sv
// rtl/ifetch_q.sv - instruction fetch stage with decoupling queue and redirect
module ifetch_q
   import ifetch_q_pkg::*;
#(
   parameter int              ADDR     = ADDR_W,
   parameter int              INST     = INST_W,
   parameter int              DEPTH    = 4,
   parameter logic [ADDR-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            v_i,
   input  logic            stall_i,
   input  logic            branch_i,
   input  logic [ADDR-1:0] baddr_i,
   output logic            req_o,
   output logic [ADDR-1:0] addr_o,
   input  logic [INST-1:0] inst_i,
   output logic [INST-1:0] inst_o,
   output logic [ADDR-1:0] pc_o,
   output logic            v_o
);

   localparam int CW = cnt_w(DEPTH);

   logic [ADDR-1:0]      pc;
   logic [ADDR-1:0]      inflight_pc;
   logic                 inflight;
   logic                 pop;
   logic                 push;
   logic                 credit;
   logic [CW:0]          used;
   logic [CW:0]          limit;
   logic [ADDR+INST-1:0] fifo_dout;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [CW-1:0]        fifo_count;

   // A redirect hides the head so decode never consumes a wrong-path entry
   assign v_o = ~fifo_empty & ~branch_i;
   assign pop = v_o & ~stall_i;

   // Credit counts queued plus in-flight entries; an entry leaving this cycle
   // frees its slot, written as a comparison against DEPTH+pop to stay unsigned
   assign used   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
   assign limit  = (CW+1)'(DEPTH) + {{CW{1'b0}}, pop};
   assign credit = (used < limit);

   assign req_o  = v_i & credit & ~branch_i & ~rst;
   assign addr_o = pc;

   // The response of the previous request is dropped when a redirect lands
   assign push = inflight & ~branch_i;

   assign {pc_o, inst_o} = fifo_dout;

   // PC advance on each request, reload on redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (branch_i) begin
         pc <= baddr_i;
      end else if (req_o) begin
         pc <= pc + ADDR'(1);
      end
   end

   // Track the single outstanding memory read and the PC it belongs to
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= req_o;
         if (req_o) begin
            inflight_pc <= pc;
         end
      end
   end

   fetch_fifo #(
      .WIDTH (ADDR + INST),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({inflight_pc, inst_i}),
      .pop   (pop),
      .flush (branch_i),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   // Credit accounting must make a push into a full queue unreachable
   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_ifetch_q.sv
// tb/tb_ifetch_q.sv - directed self-checking bench for ifetch_q
module tb_ifetch_q;

   logic        clk;
   logic        rst;
   logic        v_i;
   logic        stall_i;
   logic        branch_i;
   logic [31:0] baddr_i;
   logic        req_o;
   logic [31:0] addr_o;
   logic [31:0] inst_i;
   logic [31:0] inst_o;
   logic [31:0] pc_o;
   logic        v_o;

   int checks   = 0;
   int failures = 0;

   ifetch_q #(
      .ADDR     (32),
      .INST     (32),
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .v_i      (v_i),
      .stall_i  (stall_i),
      .branch_i (branch_i),
      .baddr_i  (baddr_i),
      .req_o    (req_o),
      .addr_o   (addr_o),
      .inst_i   (inst_i),
      .inst_o   (inst_o),
      .pc_o     (pc_o),
      .v_o      (v_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: mem[k] = k + 0x100, one-cycle read latency
   initial inst_i = 32'h0;
   always @(posedge clk) begin
      if (req_o) inst_i <= addr_o + 32'h100;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic out(input string tag, input logic ev, input logic [31:0] epc, input logic [31:0] einst);
      chk({tag, ".v_o"}, 64'(v_o), 64'(ev));
      if (ev) begin
         chk({tag, ".pc_o"}, 64'(pc_o), 64'(epc));
         chk({tag, ".inst_o"}, 64'(inst_o), 64'(einst));
      end
   endtask

   task automatic reqchk(input string tag, input logic ereq, input logic [31:0] eaddr);
      chk({tag, ".req_o"}, 64'(req_o), 64'(ereq));
      chk({tag, ".addr_o"}, 64'(addr_o), 64'(eaddr));
   endtask

   task automatic cyc(input logic v, input logic s, input logic b, input logic [31:0] ba);
      @(posedge clk);
      #1;
      rst      = 1'b0;
      v_i      = v;
      stall_i  = s;
      branch_i = b;
      baddr_i  = ba;
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      v_i      = 1'b0;
      stall_i  = 1'b0;
      branch_i = 1'b0;
      baddr_i  = 32'h0;
      @(posedge clk);
   endtask

   initial begin
      rst      = 1'b1;
      v_i      = 1'b0;
      stall_i  = 1'b0;
      branch_i = 1'b0;
      baddr_i  = 32'h0;
      #2;
      chk("rst.v_o", 64'(v_o), 64'h0);
      chk("rst.inst_o", 64'(inst_o), 64'h0);
      chk("rst.pc_o", 64'(pc_o), 64'h0);
      reqchk("rst", 1'b0, 32'h0);

      // Streaming fetch: one request per cycle, output two cycles later
      do_reset();
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 32'h0);
         reqchk("stream", 1'b1, 32'(k));
         out("stream", k >= 2, 32'(k - 2), 32'(k - 2 + 32'h100));
      end

      // Stall fills the queue to DEPTH, then drains in order and fetch resumes
      do_reset();
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
         reqchk("stall_fill", k < 4, (k < 4) ? 32'(k) : 32'h4);
         out("stall_fill", k >= 2, 32'h0, 32'h100);
      end
      for (int j = 0; j < 8; j++) begin
         cyc(1'b1, 1'b0, 1'b0, 32'h0);
         reqchk("stall_drain", 1'b1, 32'(4 + j));
         out("stall_drain", 1'b1, 32'(j), 32'(32'h100 + j));
      end

      // Single-cycle redirect to 2 mid-stream
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 32'h0);
      end
      out("br_pre", 1'b1, 32'h2, 32'h102);
      cyc(1'b1, 1'b0, 1'b1, 32'h2);
      out("br_t0", 1'b0, 32'h0, 32'h0);
      reqchk("br_t0", 1'b0, 32'h5);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      out("br_t1", 1'b0, 32'h0, 32'h0);
      reqchk("br_t1", 1'b1, 32'h2);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      out("br_t2", 1'b0, 32'h0, 32'h0);
      reqchk("br_t2", 1'b1, 32'h3);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      out("br_t3", 1'b1, 32'h2, 32'h102);
      reqchk("br_t3", 1'b1, 32'h4);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      out("br_t4", 1'b1, 32'h3, 32'h103);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      out("br_t5", 1'b1, 32'h4, 32'h104);

      // Held redirect onto a full, stalled queue: last target wins
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
      end
      out("brst_full", 1'b1, 32'h0, 32'h100);
      reqchk("brst_full", 1'b0, 32'h4);
      cyc(1'b1, 1'b1, 1'b1, 32'h20);
      out("brst_b0", 1'b0, 32'h0, 32'h0);
      reqchk("brst_b0", 1'b0, 32'h4);
      cyc(1'b1, 1'b1, 1'b1, 32'h30);
      out("brst_b1", 1'b0, 32'h0, 32'h0);
      reqchk("brst_b1", 1'b0, 32'h20);
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      out("brst_a1", 1'b0, 32'h0, 32'h0);
      reqchk("brst_a1", 1'b1, 32'h30);
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      out("brst_a2", 1'b0, 32'h0, 32'h0);
      reqchk("brst_a2", 1'b1, 32'h31);
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      out("brst_a3", 1'b1, 32'h30, 32'h130);
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      out("brst_hold", 1'b1, 32'h30, 32'h130);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      out("brst_rel", 1'b1, 32'h30, 32'h130);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      out("brst_next", 1'b1, 32'h31, 32'h131);

      // Asynchronous reset with a half-full queue and a response in flight
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'h0);
      end
      out("arst_pre", 1'b1, 32'h0, 32'h100);
      rst = 1'b1;
      #1;
      chk("arst.v_o", 64'(v_o), 64'h0);
      chk("arst.pc_o", 64'(pc_o), 64'h0);
      chk("arst.inst_o", 64'(inst_o), 64'h0);
      reqchk("arst", 1'b0, 32'h0);
      @(posedge clk);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      reqchk("arst_r0", 1'b1, 32'h0);
      out("arst_r0", 1'b0, 32'h0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      out("arst_r1", 1'b0, 32'h0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      out("arst_r2", 1'b1, 32'h0, 32'h100);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      out("arst_r3", 1'b1, 32'h1, 32'h101);

      // PC wrap at the top of the address space, then v_i toggling
      do_reset();
      cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
      reqchk("wrap_b", 1'b0, 32'h0);
      out("wrap_b", 1'b0, 32'h0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      reqchk("wrap_1", 1'b1, 32'hFFFF_FFFE);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      reqchk("wrap_2", 1'b1, 32'hFFFF_FFFF);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      reqchk("wrap_3", 1'b1, 32'h0);
      out("wrap_3", 1'b1, 32'hFFFF_FFFE, 32'h0000_00FE);
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      reqchk("vtog_4", 1'b0, 32'h1);
      out("vtog_4", 1'b1, 32'hFFFF_FFFF, 32'h0000_00FF);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      reqchk("vtog_5", 1'b1, 32'h1);
      out("vtog_5", 1'b1, 32'h0, 32'h100);
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      reqchk("vtog_6", 1'b0, 32'h2);
      out("vtog_6", 1'b0, 32'h0, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      reqchk("vtog_7", 1'b1, 32'h2);
      out("vtog_7", 1'b1, 32'h1, 32'h101);
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      reqchk("vtog_8", 1'b0, 32'h3);
      out("vtog_8", 1'b0, 32'h0, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      reqchk("vtog_9", 1'b0, 32'h3);
      out("vtog_9", 1'b1, 32'h2, 32'h102);
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      out("vtog_10", 1'b0, 32'h0, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifetch_q.md
Name: ifetch_q

Overview:
- Parametrised instruction-fetch stage with a decoupling instruction queue.
- Generates a word-indexed PC and issues one request per cycle to a synchronous instruction memory (1-cycle read latency).
- Stores returned {pc, inst} pairs in a DEPTH-entry queue and presents them to decode under a valid/stall handshake.
- Branch redirect flushes the queue, squashes the in-flight response and restarts at baddr_i.

Parameters:
ADDR, 32, PC / memory address width in words (shared params.vh value)
INST, 32, instruction width (shared params.vh value)
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
v_i  in  1  fetch enable; 0 holds the PC and issues nothing
stall_i  in  1  decode not ready; the head entry is held
branch_i  in  1  redirect request, single-cycle pulse or held
baddr_i  in  ADDR  redirect target, sampled when branch_i=1
req_o  in/out: out  1  memory read request this cycle
addr_o  out  ADDR  memory read address (= current PC)
inst_i  in  INST  memory read data, valid the cycle after req_o=1
inst_o  out  INST  head instruction
pc_o  out  ADDR  PC of the head instruction
v_o  out  1  head valid

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC; queue empty (count=0, rd/wr pointers 0); inflight=0; all entries 0.
  - v_o=0, inst_o=0, pc_o=0, req_o=0, addr_o=RESET_PC.
  - Reset mid-operation discards everything, including any response due next cycle.
- Pop: pop = v_o & ~stall_i. Head advances at the clock edge.
- Credit and request:
  - credit = (count + inflight - pop) < DEPTH.
  - req_o = v_i & credit & ~branch_i & ~rst.
  - addr_o = pc at all times.
  - On req_o, at the edge: pc <= pc+1 (wraps modulo 2^ADDR); inflight <= 1; inflight_pc <= pc. Otherwise inflight <= 0.
- Response: when inflight=1 and no branch this cycle, {inflight_pc, inst_i} is pushed at the edge.
  - Overflow is impossible by construction; an assertion checks push & full never occurs.
  - Push and pop in the same cycle is legal at any count, including full; count is unchanged.
- Latency:
  - req in cycle t -> entry written at end of t+1 -> v_o=1 in t+2.
  - Sustained throughput is 1 instruction/cycle with stall_i=0.
- Stall: with stall_i=1, the queue fills to DEPTH and req_o drops.
  - The last request is issued when count+inflight reaches DEPTH.
  - inst_o/pc_o stay stable while stalled.
- Branch (branch_i=1 in cycle t):
  - v_o is forced 0 in cycle t, so no pop.
  - Queue is flushed at the edge.
  - An inflight response arriving in t is dropped; inflight <= 0.
  - pc <= baddr_i; req_o=0 in t.
  - Cycle t+1: addr_o=baddr_i, and req_o=1 if v_i=1 (1-cycle bubble).
  - First target instruction is at v_o in t+3.
- Branch with stall_i=1: the branch wins and the flush still happens.
- Branch held for several cycles: each cycle re-flushes and reloads pc from baddr_i.
- v_i=0: no new requests; an inflight response still completes; the queue still drains to decode.
- Pointer arithmetic:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.

Decomposition:
- Shared params.vh:
  - ADDR, INST.
  - NOP encoding (not injected by this block, but used by benches for memory fill).
- One natural sub-module, fetch_fifo: synchronous FIFO with flush input.
  - Parameters: WIDTH=ADDR+INST, DEPTH.
  - Ports: clk, rst, push, din, pop, flush, dout, empty, full, count.
- ifetch_q keeps the PC, inflight tracking, credit logic and branch control.

Test Plan:
- Reset release, v_i=1, stall_i=0, mem[k]=k+0x100 -> addr_o 0,1,2,... one per cycle; v_o rises 2 cycles after the first req; (pc_o,inst_o) = (0,0x100),(1,0x101),... back-to-back.
- stall_i=1 from cycle 3, DEPTH=4 -> queue reaches count=4; req_o=0 with addr_o held at 4; inst_o=0x100 stable. Release stall -> 0x100..0x103 drain in order, then fetch resumes at 4 with no gap or duplicate.
- Steady stream, branch_i=1 for one cycle, baddr_i=2 -> v_o=0 that cycle and the next two; no wrong-path entry ever appears; next valid output is (2,0x102), then (3,0x103).
- branch_i with stall_i=1 and a full queue -> queue empties; first output after redirect is pc=baddr_i.
- rst asserted mid-stream with the queue half full -> v_o=0 immediately (asynchronous); after release the first output is pc=RESET_PC; the pre-reset inflight data is never output.
- ADDR=4, pc run through 14,15 -> addr_o wraps 15->0; v_i toggling 1/0 -> no requests while v_i=0; order is preserved.
